circular_fifo: RTL and testbench

// - Synchronous single-clock FIFO with an optional circular (rotate) mode.
// - Normal mode: a read pops the head word. Circular mode: a read moves the head word
//   to the tail, so stored words cycle endlessly without being consumed.
// - Used as a generic buffer or replay/pattern store. The read/write side is carried
//   by the shared fifo_connect bundle; clk, reset and circular are separate ports.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_connect.sv | 32 +++
 rtl/fifo_mem.sv | 28 ++
 rtl/circular_fifo.sv | 134 +++++++++++++
 tb/tb_circular_fifo.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions.
// Holds the default geometry of the FIFO family and the helper that sizes the
// occupancy counter, so the interface and the FIFO agree on the count width.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int FIFO_WIDTH_DEFAULT = 32;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_connect.sv
// Read/write bundle shared between a FIFO and its user.
// Signals: write/datain (push), read (pop or rotate), dataout (head word),
// full/empty/count (occupancy). The fifo modport is the FIFO side, the user
// modport is the requester side.
interface fifo_connect
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = FIFO_WIDTH_DEFAULT
) ();

  localparam int CW = count_width(DEPTH);

  logic             write;
  logic [WIDTH-1:0] datain;
  logic             read;
  logic [WIDTH-1:0] dataout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport fifo (
    input  write, datain, read,
    output dataout, full, empty, count
  );

  modport user (
    output write, datain, read,
    input  dataout, full, empty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: DEPTH x WIDTH registers, one synchronous write
// port and one combinational read port. Contents are deliberately not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Word write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/circular_fifo.sv
// Single-clock FIFO with an optional circular (rotate) mode.
// In normal mode a read pops the head; in circular mode a read copies the head
// word to the tail and advances both pointers, so the stored words replay.
// Ports: clk, reset (async, active-high), circular (rotate select), fc
// (fifo_connect bundle: write/datain/read in, dataout/full/empty/count out).
module circular_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH                 = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH                 = FIFO_WIDTH_DEFAULT,
  parameter int FIRSTWORD_FALLTHROUGH = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     circular,
  fifo_connect.fifo fc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;

  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             rot_s;
  logic             mem_we_s;
  logic [WIDTH-1:0] mem_wdata_s;
  logic [WIDTH-1:0] mem_rdata_s;
  logic [CW-1:0]    count_next_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  // Accept decisions. A write is blocked whenever a rotate is requested, since
  // the rotate owns the write port that cycle.
  always_comb begin
    rd_ok_s  = fc.read & ~empty_r;
    wr_ok_s  = fc.write & (~full_r | rd_ok_s) & ~(circular & fc.read);
    rot_s    = circular & rd_ok_s;
    mem_we_s = wr_ok_s | rot_s;
    if (rot_s) begin
      mem_wdata_s = mem_rdata_s;
    end else begin
      mem_wdata_s = fc.datain;
    end
  end

  // Next occupancy; a rotate moves a word without changing the count.
  always_comb begin
    count_next_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10: count_next_s = count_r + CW'(1);
      2'b01: begin
        if (circular) begin
          count_next_s = count_r;
        end else begin
          count_next_s = count_r - CW'(1);
        end
      end
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; full/empty are registered with count so
  // all three change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (rd_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (mem_we_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (mem_wdata_s),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata_s)
  );

  generate
    if (FIRSTWORD_FALLTHROUGH != 0) begin : g_fwft
      // Head word shown directly; forced to zero while nothing is stored.
      assign fc.dataout = empty_r ? {WIDTH{1'b0}} : mem_rdata_s;
    end else begin : g_reg
      logic [WIDTH-1:0] dataout_r;

      // Registered head capture on each accepted read.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dataout_r <= {WIDTH{1'b0}};
        end else if (rd_ok_s) begin
          dataout_r <= mem_rdata_s;
        end
      end

      assign fc.dataout = dataout_r;
    end
  endgenerate

  assign fc.count = count_r;
  assign fc.full  = full_r;
  assign fc.empty = empty_r;

endmodule

// File: tb/tb_circular_fifo.sv
// Directed self-checking bench for circular_fifo (DEPTH 4, WIDTH 32, FWFT 1).
module tb_circular_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  logic circular;
  int   check_count;
  int   error_count;

  fifo_connect #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  circular_fifo #(
    .DEPTH                 (DEPTH),
    .WIDTH                 (WIDTH),
    .FIRSTWORD_FALLTHROUGH (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .circular (circular),
    .fc       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.write  = 1'b1;
    bus.read   = 1'b0;
    bus.datain = d;
    step();
    bus.write  = 1'b0;
  endtask

  logic [31:0] exp_q [4];
  logic [31:0] rot_q [3];

  initial begin
    check_count = 0;
    error_count = 0;
    reset       = 1'b1;
    circular    = 1'b0;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.datain  = 32'd0;
    #1;
    check_value("rst_count", 32'(bus.count), 32'd0);
    check_value("rst_empty", 32'(bus.empty), 32'd1);
    check_value("rst_full", 32'(bus.full), 32'd0);
    check_value("rst_dataout", bus.dataout, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Read while empty is ignored.
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    check_value("empty_read_count", 32'(bus.count), 32'd0);

    // Simultaneous read+write on empty: only the write lands.
    bus.write  = 1'b1;
    bus.read   = 1'b1;
    bus.datain = 32'd9;
    step();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    check_value("rw_empty_count", 32'(bus.count), 32'd1);
    check_value("rw_empty_dataout", bus.dataout, 32'd9);
    check_value("rw_empty_empty", 32'(bus.empty), 32'd0);
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    check_value("pop9_count", 32'(bus.count), 32'd0);
    check_value("pop9_empty", 32'(bus.empty), 32'd1);
    check_value("pop9_dataout", bus.dataout, 32'd0);

    // Fill, overflow write dropped, drain in order.
    for (int i = 0; i < 4; i++) push(32'(i + 2));
    check_value("fill_full", 32'(bus.full), 32'd1);
    check_value("fill_count", 32'(bus.count), 32'd4);
    push(32'd6);
    check_value("ovf_count", 32'(bus.count), 32'd4);
    check_value("ovf_head", bus.dataout, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_value("drain_data", bus.dataout, 32'(i + 2));
      bus.read = 1'b1;
      step();
      bus.read = 1'b0;
    end
    check_value("drain_empty", 32'(bus.empty), 32'd1);
    check_value("drain_count", 32'(bus.count), 32'd0);

    // Full with simultaneous read+write.
    for (int i = 0; i < 4; i++) push(32'(i + 2));
    bus.write  = 1'b1;
    bus.read   = 1'b1;
    bus.datain = 32'd7;
    step();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    check_value("full_rw_head", bus.dataout, 32'd3);
    check_value("full_rw_count", 32'(bus.count), 32'd4);
    check_value("full_rw_full", 32'(bus.full), 32'd1);
    exp_q[0] = 32'd3;
    exp_q[1] = 32'd4;
    exp_q[2] = 32'd5;
    exp_q[3] = 32'd7;
    for (int i = 0; i < 4; i++) begin
      check_value("full_rw_drain", bus.dataout, exp_q[i]);
      bus.read = 1'b1;
      step();
      bus.read = 1'b0;
    end
    check_value("full_rw_empty", 32'(bus.empty), 32'd1);

    // Circular replay.
    push(32'd10);
    push(32'd14);
    push(32'd1151);
    rot_q[0] = 32'd10;
    rot_q[1] = 32'd14;
    rot_q[2] = 32'd1151;
    circular = 1'b1;
    bus.read = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check_value("rot_data", bus.dataout, rot_q[i % 3]);
      step();
      check_value("rot_count", 32'(bus.count), 32'd3);
    end
    check_value("rot_wrap_head", bus.dataout, 32'd10);

    // Circular: write alongside read is dropped, then append works.
    bus.write  = 1'b1;
    bus.datain = 32'd0;
    step();
    check_value("rot_wdrop_count", 32'(bus.count), 32'd3);
    check_value("rot_wdrop_head", bus.dataout, 32'd14);
    bus.read = 1'b0;
    step();
    bus.write = 1'b0;
    check_value("rot_append_count", 32'(bus.count), 32'd4);
    check_value("rot_append_full", 32'(bus.full), 32'd1);

    // Back to normal mode, pop one to leave count = 3, then async reset.
    circular = 1'b0;
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    check_value("pre_rst_count", 32'(bus.count), 32'd3);
    check_value("pre_rst_head", bus.dataout, 32'd1151);
    #2;
    reset = 1'b1;
    #1;
    check_value("async_rst_empty", 32'(bus.empty), 32'd1);
    check_value("async_rst_count", 32'(bus.count), 32'd0);
    check_value("async_rst_dataout", bus.dataout, 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
